// File: rtl/fp_mult_vec_loader_if.sv
// Operand/handshake bundle between the fetch logic, the vector loader and
// the multiplier array. The master side is the loader itself.
interface fp_mult_vec_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LANES  = 32
);
  // serial operand stream
  logic                              in_vld;
  logic                              in_rdy;
  logic [DATA_WIDTH-1:0]             in_weight;
  logic [DATA_WIDTH-1:0]             in_data;
  logic                              in_last;
  logic                              in_op_sel;
  // multiplier array side
  logic [NUM_LANES*DATA_WIDTH-1:0]   weight_bank;
  logic [NUM_LANES*DATA_WIDTH-1:0]   data_bank;
  logic                              mult_en;
  logic                              mult_op_sel;
  logic                              prod_vec_vld;
  logic                              vec_done;
  logic                              timeout_err;

  modport master (
    input  in_vld, in_weight, in_data, in_last, in_op_sel, prod_vec_vld,
    output in_rdy, weight_bank, data_bank, mult_en, mult_op_sel,
           vec_done, timeout_err
  );

  modport slave (
    output in_vld, in_weight, in_data, in_last, in_op_sel, prod_vec_vld,
    input  in_rdy, weight_bank, data_bank, mult_en, mult_op_sel,
           vec_done, timeout_err
  );
endinterface

// File: rtl/fp_mult_vec_loader.sv
// Vector loader for the multiplier array: packs a serial stream of
// (weight, feature) pairs into per-lane operand registers, zero-pads short
// vectors, fires the array and waits (bounded) for the all-lanes product valid.

// One lane of operand storage: a weight/feature register pair.
module fp_mult_vec_loader_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] w_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] w_o,
  output logic [DATA_WIDTH-1:0] d_o
);
  logic [DATA_WIDTH-1:0] w_q, d_q;

  // operand capture; holds until this lane is written again
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0;
      d_q <= '0;
    end else if (wr_en_i) begin
      w_q <= w_i;
      d_q <= d_i;
    end
  end

  assign w_o = w_q;
  assign d_o = d_q;
endmodule

module fp_mult_vec_loader #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_LANES   = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fp_mult_vec_loader_if.master  bus
);
  localparam int IDX_W = (NUM_LANES   > 1) ? $clog2(NUM_LANES)   : 1;
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {S_LOAD, S_PAD, S_ISSUE, S_WAIT} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic                  op_sel_q, op_sel_d;
  logic                  done_q, done_d;
  logic                  tmo_q, tmo_d;
  logic                  lane_wr;
  logic                  lane_zero;
  logic                  last_lane;
  logic [DATA_WIDTH-1:0] wr_w, wr_d;

  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] w_bank, d_bank;

  assign last_lane = (idx_q == IDX_W'(NUM_LANES - 1));

  // state, lane index, wait timer and sticky status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_LOAD;
      idx_q    <= '0;
      tmr_q    <= '0;
      op_sel_q <= 1'b0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tmr_q    <= tmr_d;
      op_sel_q <= op_sel_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
    end
  end

  // next-state: load beats, zero-fill the tail, fire, then wait for products
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tmr_d     = tmr_q;
    op_sel_d  = op_sel_q;
    done_d    = 1'b0;
    tmo_d     = tmo_q;
    lane_wr   = 1'b0;
    lane_zero = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        if (bus.in_vld) begin
          lane_wr = 1'b1;
          if (idx_q == '0) begin
            op_sel_d = bus.in_op_sel;
            tmo_d    = 1'b0;
          end
          // the index saturates on the top lane so it never wraps mid-vector;
          // in_last there is redundant and ignored
          if (last_lane) begin
            state_d = S_ISSUE;
          end else begin
            idx_d = idx_q + 1'b1;
            if (bus.in_last) state_d = S_PAD;
          end
        end
      end
      S_PAD: begin
        lane_wr   = 1'b1;
        lane_zero = 1'b1;
        if (last_lane) state_d = S_ISSUE;
        else           idx_d   = idx_q + 1'b1;
      end
      S_ISSUE: begin
        tmr_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // a product-valid on the timeout cycle still counts as success
        if (bus.prod_vec_vld) begin
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = S_LOAD;
        end else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          tmo_d   = 1'b1;
          idx_d   = '0;
          state_d = S_LOAD;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // shared write data; PAD lanes get +0.0
  always_comb begin
    wr_w = bus.in_weight;
    wr_d = bus.in_data;
    if (lane_zero) begin
      wr_w = '0;
      wr_d = '0;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    fp_mult_vec_loader_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en_i (lane_wr && (idx_q == IDX_W'(g))),
      .w_i     (wr_w),
      .d_i     (wr_d),
      .w_o     (w_bank[g]),
      .d_o     (d_bank[g])
    );
  end

  // in_rdy is gated by reset so every output reads 0 while reset is held;
  // mult_en is decoded from state so an async reset drops it immediately
  assign bus.in_rdy      = rst_n && (state_q == S_LOAD);
  assign bus.mult_en     = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign bus.mult_op_sel = op_sel_q;
  assign bus.vec_done    = done_q;
  assign bus.timeout_err = tmo_q;
  assign bus.weight_bank = w_bank;
  assign bus.data_bank   = d_bank;
endmodule

// File: tb/tb_fp_mult_vec_loader.sv
// Directed bench for fp_mult_vec_loader: a table of vector scenarios plus
// hand-written reset and out-of-state sequences.
module tb_fp_mult_vec_loader;
  localparam int DW = 32;
  localparam int NL = 32;
  localparam int BW = DW * NL;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_mult_vec_loader_if #(.DATA_WIDTH(DW), .NUM_LANES(NL)) bus ();

  fp_mult_vec_loader #(.DATA_WIDTH(DW), .NUM_LANES(NL), .TIMEOUT_CYC(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int n;         // beats sent
    bit last;      // drive in_last on the final beat
    bit op;        // op_sel on the first beat
    bit gap;       // idle cycle before every odd beat
    int prod_d;    // WAIT cycle index for prod_vec_vld, -1 = never
    int exp_pad;   // PAD cycles before mult_en
    bit exp_done;
    bit exp_tmo;
  } vec_t;

  vec_t tbl[9];
  int   checks = 0;
  int   errors = 0;
  bit   prev_op  = 1'b0;
  bit   prev_tmo = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_bank(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    int bad;
    checks++;
    bad = -1;
    for (int i = NL - 1; i >= 0; i--)
      if (act[i*DW +: DW] !== exp[i*DW +: DW]) bad = i;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s lane %0d actual=%0h required=%0h", nm, bad,
               act[bad*DW +: DW], exp[bad*DW +: DW]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] fp32(input int i);
    int p;
    if (i == 0) return 32'h0;
    p = 0;
    for (int b = 0; b < 31; b++) if (i[b]) p = b;
    return {1'b0, 8'(127 + p), 23'((i << (23 - p)) & 32'h007F_FFFF)};
  endfunction

  function automatic logic [31:0] wgen(input int id, input int i);
    if (id == 0) return 32'h3F80_0000;
    return {8'(id), 8'hA5, 16'(i + 1)};
  endfunction

  function automatic logic [31:0] dgen(input int id, input int i);
    if (id == 0) return fp32(i);
    return {8'h5A, 8'(id), 16'(i + 7)};
  endfunction

  task automatic junk_inputs(input bit op);
    bus.in_vld    = 1'b1;
    bus.in_weight = 32'hDEAD_BEEF;
    bus.in_data   = 32'hBADC_0FFE;
    bus.in_last   = 1'b1;
    bus.in_op_sel = ~op;
  endtask

  task automatic run_vector(input vec_t v, input int id);
    logic [BW-1:0] ew, ed;
    bit rdy_bad, wait_bad;
    int k;
    ew = '0;
    ed = '0;
    for (int i = 0; i < v.n; i++) begin
      ew[i*DW +: DW] = wgen(id, i);
      ed[i*DW +: DW] = dgen(id, i);
    end
    chk($sformatf("v%0d rdy_idle", id), 32'(bus.in_rdy), 32'd1);
    chk($sformatf("v%0d op_hold", id), 32'(bus.mult_op_sel), 32'(prev_op));
    chk($sformatf("v%0d tmo_sticky", id), 32'(bus.timeout_err), 32'(prev_tmo));
    rdy_bad = 1'b0;
    for (int i = 0; i < v.n; i++) begin
      if (v.gap && i[0]) begin
        bus.in_vld = 1'b0;
        step();
      end
      bus.in_vld    = 1'b1;
      bus.in_weight = wgen(id, i);
      bus.in_data   = dgen(id, i);
      bus.in_last   = v.last && (i == v.n - 1);
      bus.in_op_sel = (i == 0) ? v.op : ~v.op;
      if (!bus.in_rdy) rdy_bad = 1'b1;
      step();
      if (i == 0) begin
        chk($sformatf("v%0d op_latch", id), 32'(bus.mult_op_sel), 32'(v.op));
        chk($sformatf("v%0d tmo_clear", id), 32'(bus.timeout_err), 32'd0);
      end
    end
    chk($sformatf("v%0d rdy_load", id), 32'(rdy_bad), 32'd0);
    junk_inputs(v.op);
    k = 0;
    wait_bad = 1'b0;
    while (!bus.mult_en && k < 100) begin
      if (bus.in_rdy) wait_bad = 1'b1;
      step();
      k++;
    end
    chk($sformatf("v%0d pad_cycles", id), 32'(k), 32'(v.exp_pad));
    if (bus.in_rdy) wait_bad = 1'b1;
    step();
    if (v.prod_d >= 0) begin
      for (int c = 0; c < v.prod_d; c++) begin
        if (bus.in_rdy || !bus.mult_en || bus.vec_done) wait_bad = 1'b1;
        step();
      end
      bus.prod_vec_vld = 1'b1;
      step();
      bus.prod_vec_vld = 1'b0;
      bus.in_vld = 1'b0;
    end else begin
      k = 0;
      while (bus.mult_en && k < 200) begin
        if (bus.in_rdy || bus.vec_done) wait_bad = 1'b1;
        step();
        k++;
      end
      bus.in_vld = 1'b0;
      chk($sformatf("v%0d wait_cycles", id), 32'(k), 32'd64);
    end
    chk($sformatf("v%0d rdy_busy", id), 32'(wait_bad), 32'd0);
    chk($sformatf("v%0d vec_done", id), 32'(bus.vec_done), 32'(v.exp_done));
    chk($sformatf("v%0d timeout_err", id), 32'(bus.timeout_err), 32'(v.exp_tmo));
    chk($sformatf("v%0d mult_en_off", id), 32'(bus.mult_en), 32'd0);
    chk($sformatf("v%0d op_frozen", id), 32'(bus.mult_op_sel), 32'(v.op));
    step();
    chk($sformatf("v%0d done_pulse", id), 32'(bus.vec_done), 32'd0);
    chk_bank($sformatf("v%0d weight_bank", id), bus.weight_bank, ew);
    chk_bank($sformatf("v%0d data_bank", id), bus.data_bank, ed);
    prev_op  = v.op;
    prev_tmo = v.exp_tmo;
  endtask

  task automatic send_n(input int n, input int id);
    for (int i = 0; i < n; i++) begin
      bus.in_vld    = 1'b1;
      bus.in_weight = wgen(id, i);
      bus.in_data   = dgen(id, i);
      bus.in_last   = 1'b0;
      bus.in_op_sel = 1'b1;
      step();
    end
    bus.in_vld = 1'b0;
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, " mult_en"}, 32'(bus.mult_en), 32'd0);
    chk({nm, " vec_done"}, 32'(bus.vec_done), 32'd0);
    chk({nm, " in_rdy"}, 32'(bus.in_rdy), 32'd0);
    chk_bank({nm, " weight_bank"}, bus.weight_bank, '0);
    chk_bank({nm, " data_bank"}, bus.data_bank, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    //         n   last op gap prod pad done tmo
    tbl[0] = '{32, 0, 0, 0,  4,  0, 1, 0};
    tbl[1] = '{ 5, 1, 1, 0,  0, 27, 1, 0};
    tbl[2] = '{20, 1, 0, 1, -1, 12, 0, 1};
    tbl[3] = '{ 3, 1, 1, 0, 63, 29, 1, 0};
    tbl[4] = '{ 1, 1, 0, 0, 62, 31, 1, 0};
    tbl[5] = '{32, 1, 1, 0, 10,  0, 1, 0};
    tbl[6] = '{32, 0, 0, 0,  0,  0, 1, 0};
    tbl[7] = '{31, 1, 1, 1, -1,  1, 0, 1};
    tbl[8] = '{ 2, 1, 1, 0,  5, 30, 1, 0};

    bus.in_vld = 1'b0;
    bus.in_weight = '0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.in_op_sel = 1'b0;
    bus.prod_vec_vld = 1'b0;

    #12;
    chk_reset_state("reset");
    chk("reset timeout_err", 32'(bus.timeout_err), 32'd0);
    chk("reset mult_op_sel", 32'(bus.mult_op_sel), 32'd0);
    rst_n = 1'b1;
    step();

    for (int t = 0; t < 9; t++) run_vector(tbl[t], t);

    // product-valid outside WAIT must be ignored
    bus.prod_vec_vld = 1'b1;
    step();
    step();
    chk("stray_prod vec_done", 32'(bus.vec_done), 32'd0);
    chk("stray_prod mult_en", 32'(bus.mult_en), 32'd0);
    bus.prod_vec_vld = 1'b0;

    // async reset while waiting on the array
    send_n(32, 11);
    step();
    step();
    chk("pre_rst mult_en", 32'(bus.mult_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("rst_wait");
    #3;
    rst_n = 1'b1;
    step();
    chk("rst_wait rdy_after", 32'(bus.in_rdy), 32'd1);

    // async reset part way through loading
    send_n(10, 12);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("rst_beat10");
    #3;
    rst_n = 1'b1;
    step();
    chk("rst_beat10 rdy_after", 32'(bus.in_rdy), 32'd1);
    prev_op  = 1'b0;
    prev_tmo = 1'b0;

    // normal operation resumes after reset
    run_vector(tbl[1], 13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
